seq_mult_32bit: RTL

- Iterative unsigned 32x32->64 shift-and-add multiplier for the ALU's multiply path.
- Sits directly upstream of the team's 32-bit CLA adder (cla_32bit). It drives that adder's operands every cycle and consumes its sum.
- One partial-product add and shift per clock; 32 iterations per multiply.
- Start/busy/done handshake toward the ALU control.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/cla_32bit.sv | 38 +++
 rtl/seq_mult_32bit.sv | 95 +++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: widths, state encoding, carry recovery.
// No logic of its own; imported by seq_mult_32bit.
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } mult_state_t;

  // The adder has no carry-out port; rebuild it from the operand and sum MSBs.
  function automatic logic carry_out(input logic x_msb, input logic y_msb, input logic s_msb);
    return (x_msb & y_msb) | ((x_msb ^ y_msb) & ~s_msb);
  endfunction

endpackage

// File: rtl/cla_32bit.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
// Purely combinational, zero latency, no flow control.
module cla_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic        cy;

  always_comb begin
    g   = a & b;
    p   = a ^ b;
    c   = '0;
    gg  = '0;
    gp  = '0;
    cy  = c_in;
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = cy;
      c[4*k+1] = g[4*k] | (p[4*k] & cy);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cy);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cy);
      gg[k]    = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k]    = &p[4*k +: 4];
      cy       = gg[k] | (gp[k] & cy);
    end
    sum = p ^ c;
  end

endmodule

// File: rtl/seq_mult_32bit.sv
// Unsigned 32x32->64 shift-and-add multiplier, one add per clock; optional SEQ_MULT_ZERO_BYPASS_EN.
// Latency 33 cycles start-to-done (1 with bypass on a zero operand); start ignored while busy.
module seq_mult_32bit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mult_state_t          state;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 co;
  logic [2*WIDTH-1:0]   shifted;

  assign addend = lo[0] ? mcand : '0;

  cla_32bit u_cla (
    .a    (hi),
    .b    (addend),
    .c_in (1'b0),
    .sum  (sum)
  );

  assign co      = carry_out(hi[WIDTH-1], addend[WIDTH-1], sum[WIDTH-1]);
  assign shifted = {co, sum, lo[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        S_RUN: begin
          {hi, lo} <= shifted;
          cnt      <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) begin
            product <= shifted;
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          // DONE behaves like IDLE so a new start in the done cycle runs back-to-back.
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            mcand <= a;
            lo    <= b;
            hi    <= '0;
            cnt   <= '0;
`ifdef SEQ_MULT_ZERO_BYPASS_EN
            if (a == '0 || b == '0) begin
              product <= '0;
              state   <= S_DONE;
              done    <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
`else
            state <= S_RUN;
            busy  <= 1'b1;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
